// File: rtl/reg_ctrl_seq.sv
// Micro-sequencer for the 4-entry register bank: takes instruction beats over valid/ready,
// then issues timed read/write/clear strobes and computes the MOV/LDI/ADD write data.
module reg_ctrl_seq #(
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_data,
    output logic              instr_ready,
    output logic [1:0]        rb_sel,
    output logic              rb_en,
    output logic              rb_load,
    output logic              rb_reset,
    output logic [DATA_W-1:0] rb_wdata,
    input  logic [DATA_W-1:0] rb_rdata,
    output logic              carry,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for an instruction beat
    // RD_S  | read strobe on rs
    // CAP_S | rs held, source operand captured after RD_WAIT cycles
    // RD_D  | read strobe on rd (ADD only)
    // CAP_D | destination operand captured after RD_WAIT cycles
    // IMM   | waiting for the LDI immediate beat
    // WR    | write strobe on rd, instruction retires
    // CLR   | clear-all strobe, instruction retires
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_S  = 3'd1;
    localparam logic [2:0] ST_CAP_S = 3'd2;
    localparam logic [2:0] ST_RD_D  = 3'd3;
    localparam logic [2:0] ST_CAP_D = 3'd4;
    localparam logic [2:0] ST_IMM   = 3'd5;
    localparam logic [2:0] ST_WR    = 3'd6;
    localparam logic [2:0] ST_CLR   = 3'd7;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam int               CNT_W    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_WAIT - 1);

    logic [2:0]        state;
    logic [1:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W:0]   sum;
    logic              xfer;

    assign sum         = {1'b0, op_a} + {1'b0, op_b};
    // Ready is forced low while reset is asserted so no beat can slip in that cycle.
    assign instr_ready = !reset && ((state == ST_IDLE) || (state == ST_IMM));
    assign xfer        = instr_valid && instr_ready;

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_WR) || (state == ST_CLR);
    assign rb_en    = (state == ST_RD_S) || (state == ST_RD_D);
    assign rb_load  = (state == ST_WR);
    assign rb_reset = (state == ST_CLR);
    assign rb_wdata = (state != ST_WR) ? '0 :
                      (op == OP_ADD)   ? sum[DATA_W-1:0] : op_a;

    always_comb begin
        rb_sel = 2'b00;
        case (state)
            ST_RD_S, ST_CAP_S:        rb_sel = rs;
            ST_RD_D, ST_CAP_D, ST_WR: rb_sel = rd;
            default:                  rb_sel = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op       <= OP_MOV;
            rd       <= 2'b00;
            rs       <= 2'b00;
            op_a     <= '0;
            op_b     <= '0;
            wait_cnt <= '0;
            carry    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        op <= instr_data[DATA_W-1:DATA_W-2];
                        rd <= instr_data[DATA_W-3:DATA_W-4];
                        rs <= instr_data[DATA_W-5:DATA_W-6];
                        case (instr_data[DATA_W-1:DATA_W-2])
                            OP_LDI:  state <= ST_IMM;
                            OP_CLR:  state <= ST_CLR;
                            default: state <= ST_RD_S;
                        endcase
                    end
                end
                ST_RD_S: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_CAP_S;
                end
                ST_CAP_S: begin
                    if (wait_cnt == '0) begin
                        op_a  <= rb_rdata;
                        state <= (op == OP_ADD) ? ST_RD_D : ST_WR;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RD_D: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= ST_CAP_D;
                end
                ST_CAP_D: begin
                    if (wait_cnt == '0) begin
                        op_b  <= rb_rdata;
                        state <= ST_WR;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_IMM: begin
                    if (xfer) begin
                        op_a  <= instr_data;
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (op == OP_ADD) begin
                        carry <= sum[DATA_W];
                    end
                    state <= ST_IDLE;
                end
                ST_CLR: begin
                    carry <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
